pcileech_cfgspace_cpl_tx: RTL and testbench
===========================================

PCILEECH_CFGSPACE_CPL_TX -- requirements
Module: pcileech_cfgspace_cpl_tx

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of buffered completion requests (power of two, 2..16).
REQ-002 clk_pcie  input  1  sole clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 pcie_id  input  16  completer ID placed in DW1[31:16].
REQ-005 req_valid  input  1  completion request present.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready at a clock edge.
REQ-007 req_is_wr  input  1  1 = request answers a CfgWr (no data); 0 = answers a CfgRd.
REQ-008 req_status  input  3  completion status: 000 SC, 001 UR, 100 CA.
REQ-009 req_tag  input  8  tag of the originating request.
REQ-010 req_reqid  input  16  requester ID of the originating request.
REQ-011 req_data  input  32  read data, used only for CfgRd with SC.
REQ-012 tlps_tdata  output  128  completion TLP; DW0 in [31:0], DW1 [63:32], DW2 [95:64], DW3 [127:96].
REQ-013 tlps_tkeep  output  4  per-DW valid mask.
REQ-014 tlps_tlast  output  1  end of TLP; always 1 when tlps_tvalid.
REQ-015 tlps_tvalid  output  1  output beat valid.
REQ-016 tlps_tready  input  1  sink accepts the beat when tlps_tvalid && tlps_tready.
REQ-017 cpl_count  output  16  completions transmitted, wraps at 0xFFFF->0x0000.
REQ-018 err_count  output  16  non-SC completions transmitted, wraps.

Function
REQ-019 Accepted requests SHALL enter a FIFO_DEPTH-entry FIFO in order; req_ready = FIFO not full (combinational from occupancy).
REQ-020 Push while full is impossible by REQ-019; a push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-021 req_status values other than 000/001/100 SHALL be transmitted as 100 (CA).
REQ-022 CfgRd with SC SHALL produce CplD: DW0 = 0x4A000001, tkeep = 4'b1111, DW3 = req_data.
REQ-023 CfgWr (any status) or CfgRd with UR/CA SHALL produce Cpl: DW0 = 0x0A000000, tkeep = 4'b0111, DW3 = 0.
REQ-024 DW1 SHALL be {pcie_id, status[2:0], 1'b0 BCM, 12'd4}; DW2 SHALL be {req_reqid, req_tag, 1'b0, 7'd0}.
REQ-025 pcie_id SHALL be sampled when the TLP is loaded into the output register, not at request acceptance.
REQ-026 FSM states IDLE (tvalid 0) and SEND (tvalid 1).
REQ-027 IDLE: FIFO non-empty -> pop head, load output register, go SEND; else stay.
REQ-028 SEND, tready 0: all tlps_* outputs SHALL hold stable.
REQ-029 SEND, tready 1: FIFO non-empty -> pop and load next TLP (back-to-back, tvalid stays 1); else go IDLE.
REQ-030 Latency: a request accepted at edge N into an empty FIFO with FSM in IDLE SHALL show tlps_tvalid = 1 after edge N+1.
REQ-031 Sustained throughput SHALL be one TLP per cycle while tlps_tready = 1.
REQ-032 cpl_count SHALL increment on each tvalid && tready handshake; err_count also when transmitted status != SC.
REQ-033 Requests SHALL be transmitted in acceptance order with no loss or duplication.

Reset
REQ-034 On rst_n low, asynchronously: FIFO empty, FSM IDLE, tlps_tvalid 0, tlps_tdata 0, tlps_tkeep 0, tlps_tlast 0, cpl_count 0, err_count 0; req_ready 1 after release.
REQ-035 Reset during SEND SHALL discard the pending TLP and all buffered requests; no partial beat after release.

Verification
REQ-036 CfgRd SC, tag 0x12, reqid 0x0100, data 0xDEADBEEF, pcie_id 0x0300, tready 1 -> one beat: DW0 0x4A000001, DW1 0x03000004, DW2 0x01001200, DW3 0xDEADBEEF, tkeep 1111, tlast 1; cpl_count 1.
REQ-037 CfgWr SC, tag 0x05 -> DW0 0x0A000000, tkeep 0111, DW3 0; cpl_count +1, err_count unchanged.
REQ-038 CfgRd status 001 then status 011 -> both Cpl, status fields 001 and 100; err_count 2.
REQ-039 tready held 0, push 5 requests (depth 4) -> 1 in output, 4 in FIFO, req_ready 0; release tready -> 5 TLPs in order on consecutive cycles.
REQ-040 tready toggling randomly for 200 requests -> outputs stable while stalled, order preserved, cpl_count 200.
REQ-041 rst_n asserted while tvalid 1 with 3 queued -> outputs zero immediately, no TLP emitted after release, counters 0.

Source files
------------

// File: rtl/pcileech_cfgspace_cpl_tx.sv
// pcileech_cfgspace_cpl_tx: buffers config-space completion requests and emits them as single-beat Cpl/CplD TLPs.
module pcileech_cfgspace_cpl_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk_pcie,
    input  logic         rst_n,
    input  logic [15:0]  pcie_id,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_is_wr,
    input  logic [2:0]   req_status,
    input  logic [7:0]   req_tag,
    input  logic [15:0]  req_reqid,
    input  logic [31:0]  req_data,
    output logic [127:0] tlps_tdata,
    output logic [3:0]   tlps_tkeep,
    output logic         tlps_tlast,
    output logic         tlps_tvalid,
    input  logic         tlps_tready,
    output logic [15:0]  cpl_count,
    output logic [15:0]  err_count
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic        is_wr;
        logic [2:0]  st;
        logic [7:0]  tag;
        logic [15:0] reqid;
        logic [31:0] data;
    } ent_t;

    typedef enum logic {IDLE, SEND} state_t;

    ent_t            mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wp_q, rp_q;
    logic [AW:0]     cnt_q;
    state_t          state_q;
    logic [127:0]    tdata_q;
    logic [3:0]      tkeep_q;
    logic            tlast_q, tvalid_q;
    logic [15:0]     cpl_q, err_q;
    ent_t            h;
    logic [2:0]      st_d;
    logic            cpld, push, pop, empty, xfer;
    logic [127:0]    tdata_d;

    assign empty     = cnt_q == '0;
    assign req_ready = cnt_q != (AW+1)'(FIFO_DEPTH);
    assign push      = req_valid && req_ready;
    assign xfer      = state_q == SEND && tlps_tready;
    assign pop       = !empty && (state_q == IDLE || tlps_tready);
    assign h         = mem_q[rp_q];
    // Reserved/unknown status codes go out as Completer Abort
    assign st_d      = (h.st == 3'b000 || h.st == 3'b001 || h.st == 3'b100) ? h.st : 3'b100;
    assign cpld      = !h.is_wr && st_d == 3'b000;
    assign tdata_d   = {cpld ? h.data : 32'h0,
                        h.reqid, h.tag, 8'h00,
                        pcie_id, st_d, 1'b0, 12'd4,
                        cpld ? 32'h4A000001 : 32'h0A000000};

    always_ff @(posedge clk_pcie) begin
        if (push) mem_q[wp_q] <= '{req_is_wr, req_status, req_tag, req_reqid, req_data};
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(push);
            rp_q  <= rp_q + AW'(pop);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            cpl_q    <= '0;
            err_q    <= '0;
        end else begin
            if (xfer) begin
                cpl_q <= cpl_q + 16'd1;
                if (tdata_q[47:45] != 3'b000) err_q <= err_q + 16'd1;
            end
            if (pop) begin
                state_q  <= SEND;
                tdata_q  <= tdata_d;
                tkeep_q  <= cpld ? 4'b1111 : 4'b0111;
                tlast_q  <= 1'b1;
                tvalid_q <= 1'b1;
            end else if (xfer) begin
                state_q  <= IDLE;
                tlast_q  <= 1'b0;
                tvalid_q <= 1'b0;
            end
        end
    end

    assign tlps_tdata  = tdata_q;
    assign tlps_tkeep  = tkeep_q;
    assign tlps_tlast  = tlast_q;
    assign tlps_tvalid = tvalid_q;
    assign cpl_count   = cpl_q;
    assign err_count   = err_q;
endmodule

// File: tb/tb_pcileech_cfgspace_cpl_tx.sv
// tb_pcileech_cfgspace_cpl_tx: directed and randomized-ready checks of the completion transmitter.
module tb_pcileech_cfgspace_cpl_tx;
    logic         clk_pcie = 1'b0;
    logic         rst_n;
    logic [15:0]  pcie_id;
    logic         req_valid, req_ready, req_is_wr;
    logic [2:0]   req_status;
    logic [7:0]   req_tag;
    logic [15:0]  req_reqid;
    logic [31:0]  req_data;
    logic [127:0] tlps_tdata;
    logic [3:0]   tlps_tkeep;
    logic         tlps_tlast, tlps_tvalid, tlps_tready;
    logic [15:0]  cpl_count, err_count;

    int checks = 0;
    int errors = 0;

    pcileech_cfgspace_cpl_tx #(.FIFO_DEPTH(4)) dut (
        .clk_pcie(clk_pcie), .rst_n(rst_n), .pcie_id(pcie_id),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_wr(req_is_wr),
        .req_status(req_status), .req_tag(req_tag), .req_reqid(req_reqid),
        .req_data(req_data), .tlps_tdata(tlps_tdata), .tlps_tkeep(tlps_tkeep),
        .tlps_tlast(tlps_tlast), .tlps_tvalid(tlps_tvalid), .tlps_tready(tlps_tready),
        .cpl_count(cpl_count), .err_count(err_count)
    );

    always #5 clk_pcie = ~clk_pcie;

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pcie);
        #1;
    endtask

    task automatic push(input logic wr, input logic [2:0] st, input logic [7:0] tg,
                        input logic [15:0] rid, input logic [31:0] d);
        req_valid = 1'b1; req_is_wr = wr; req_status = st;
        req_tag = tg; req_reqid = rid; req_data = d;
        step();
        req_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [3:0] keep, input logic [127:0] d);
        chk(tag, {tlps_tvalid, tlps_tlast, tlps_tkeep, tlps_tdata}, {1'b1, 1'b1, keep, d});
    endtask

    function automatic logic [131:0] model(input logic wr, input logic [2:0] st, input logic [7:0] tg,
                                           input logic [15:0] rid, input logic [31:0] d,
                                           input logic [15:0] pid);
        logic [2:0] s;
        logic       c;
        s = (st == 3'd0 || st == 3'd1 || st == 3'd4) ? st : 3'd4;
        c = !wr && s == 3'd0;
        return {c ? 4'hF : 4'h7, c ? d : 32'h0, rid, tg, 8'h00, pid, s, 1'b0, 12'd4,
                c ? 32'h4A000001 : 32'h0A000000};
    endfunction

    logic [131:0] q[$];
    logic [133:0] held;
    logic         stalled, seen;
    int           rx, tx, errm, cyc;

    initial begin
        rst_n = 1'b0; pcie_id = 16'h0300; req_valid = 1'b0; req_is_wr = 1'b0;
        req_status = 3'd0; req_tag = 8'h0; req_reqid = 16'h0; req_data = 32'h0;
        tlps_tready = 1'b0;
        repeat (3) step();
        chk("rst_out", {tlps_tvalid, tlps_tlast, tlps_tkeep, tlps_tdata}, '0);
        chk("rst_cnt", {cpl_count, err_count}, '0);
        @(negedge clk_pcie) rst_n = 1'b1;
        step();
        chk("rst_ready", req_ready, 1);

        tlps_tready = 1'b1;
        push(1'b0, 3'd0, 8'h12, 16'h0100, 32'hDEADBEEF);
        chk("latency_n", tlps_tvalid, 0);
        step();
        beat("rd_sc", 4'hF, {32'hDEADBEEF, 32'h01001200, 32'h03000004, 32'h4A000001});
        step();
        chk("rd_sc_cnt", {tlps_tvalid, cpl_count, err_count}, {1'b0, 16'd1, 16'd0});

        push(1'b1, 3'd0, 8'h05, 16'h0100, 32'hFFFFFFFF);
        step();
        beat("wr_sc", 4'h7, {32'h0, 32'h01000500, 32'h03000004, 32'h0A000000});
        step();
        chk("wr_sc_cnt", {cpl_count, err_count}, {16'd2, 16'd0});

        push(1'b0, 3'd1, 8'h21, 16'h0200, 32'h11111111);
        step();
        beat("rd_ur", 4'h7, {32'h0, 32'h02002100, 32'h03002004, 32'h0A000000});
        step();
        push(1'b0, 3'd3, 8'h22, 16'h0200, 32'h22222222);
        step();
        beat("rd_bad_st", 4'h7, {32'h0, 32'h02002200, 32'h03008004, 32'h0A000000});
        step();
        chk("err_cnt", {cpl_count, err_count}, {16'd4, 16'd2});

        tlps_tready = 1'b0;
        for (int i = 0; i < 5; i++) push(1'b1, 3'd0, 8'h30 + 8'(i), 16'h0100, 32'h0);
        chk("full_ready", req_ready, 0);
        pcie_id = 16'h0400;
        repeat (3) step();
        beat("stall_hold", 4'h7, {32'h0, 32'h01003000, 32'h03000004, 32'h0A000000});
        tlps_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            beat("b2b", 4'h7, {32'h0, 16'h0100, 8'h30 + 8'(i), 8'h00,
                 i == 0 ? 32'h03000004 : 32'h04000004, 32'h0A000000});
            step();
        end
        chk("b2b_end", {tlps_tvalid, cpl_count, err_count, req_ready}, {1'b0, 16'd9, 16'd2, 1'b1});

        pcie_id = 16'h0300;
        rx = 0; tx = 0; errm = 2; cyc = 0; stalled = 1'b0; held = '0;
        while (rx < 200 && cyc < 5000) begin
            tlps_tready = 1'($urandom_range(0, 1));
            req_valid = tx < 200 && $urandom_range(0, 3) != 0;
            req_is_wr = 1'($urandom_range(0, 1));
            req_status = 3'($urandom_range(0, 7));
            req_tag = 8'($urandom);
            req_reqid = 16'($urandom);
            req_data = $urandom;
            #1;
            if (tlps_tvalid && tlps_tready) begin
                chk("rand_order", {tlps_tkeep, tlps_tdata}, q.size() > 0 ? q[0] : 132'h0);
                if (q.size() > 0) begin
                    if (q[0][47:45] != 3'd0) errm++;
                    void'(q.pop_front());
                end
                rx++;
            end
            if (req_valid && req_ready) begin
                q.push_back(model(req_is_wr, req_status, req_tag, req_reqid, req_data, pcie_id));
                tx++;
            end
            stalled = tlps_tvalid && !tlps_tready;
            held = {tlps_tvalid, tlps_tlast, tlps_tkeep, tlps_tdata};
            step();
            if (stalled) chk("rand_stable", {2'b0, tlps_tvalid, tlps_tlast, tlps_tkeep, tlps_tdata}, {2'b0, held});
            cyc++;
        end
        req_valid = 1'b0;
        chk("rand_done", rx, 200);
        chk("rand_cnt", {cpl_count, err_count}, {16'(209), 16'(errm)});

        tlps_tready = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b0, 3'd0, 8'h40 + 8'(i), 16'h0100, 32'hA5A5A5A5);
        chk("pre_rst", tlps_tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {tlps_tvalid, tlps_tlast, tlps_tkeep, tlps_tdata}, '0);
        chk("async_rst_cnt", {cpl_count, err_count}, '0);
        @(negedge clk_pcie) rst_n = 1'b1;
        tlps_tready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step();
            seen = seen | tlps_tvalid;
        end
        chk("post_rst_idle", {seen, cpl_count, err_count, req_ready}, {1'b0, 16'd0, 16'd0, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
